// File: rtl/tqvp_uart_tx_fifo.sv
// tqvp_uart_tx_fifo: UART transmitter with a transmit FIFO and a runtime frame
// format (5..PAYLOAD_BITS data bits, optional parity, one or two stop bits).
// Define UART_TX_PARITY_EN to build the parity stage; without it cfg_parity is
// ignored and frames never carry a parity bit.
module tqvp_uart_tx_fifo #(
  parameter int unsigned COUNT_REG_LEN = 13,
  parameter int unsigned PAYLOAD_BITS  = 8,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          uart_txd,
  input  logic                          tx_wr_en,
  input  logic [PAYLOAD_BITS-1:0]       tx_wr_data,
  output logic                          tx_full,
  output logic                          tx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic                          uart_tx_busy,
  output logic                          tx_done,
  input  logic [COUNT_REG_LEN-1:0]      baud_divider,
  input  logic [3:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_e;

  // FIFO storage and bookkeeping
  logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wptr_q, rptr_q;
  logic [LW-1:0]           level_q, level_d;
  logic                    push, pop;
  logic [PAYLOAD_BITS-1:0] head;

  // Frame engine state
  state_e                   state_q;
  logic [COUNT_REG_LEN-1:0] cnt_q, div_q;
  logic [PAYLOAD_BITS-1:0]  shift_q;
  logic [3:0]               nbits_q, bitcnt_q;
  logic                     par_en_q, par_bit_q, stop2_q;
  logic                     txd_q, done_q;
  logic                     next_bit;

  // Per-frame settings sampled at pop time
  logic [3:0]               cfg_nbits;
  logic                     par_en_new, par_bit_new;

  assign tx_full      = (level_q == LW'(FIFO_DEPTH));
  assign tx_empty     = (level_q == '0);
  assign tx_level     = level_q;
  assign uart_tx_busy = (state_q != S_IDLE);
  assign uart_txd     = txd_q;
  assign tx_done      = done_q;

  // Full/empty are taken from the pre-edge level, so a push into a full FIFO
  // is refused even if a pop happens in the same cycle.
  assign push     = tx_wr_en && !tx_full;
  assign pop      = (state_q == S_IDLE) && !tx_empty;
  assign head     = mem_q[rptr_q];
  assign next_bit = (cnt_q >= div_q);

  // Occupancy next-state
  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  // Clamp the data-bit count and precompute the parity bit of the head entry
  always_comb begin
    cfg_nbits = cfg_data_bits;
    if (cfg_data_bits < 4'd5 || cfg_data_bits > 4'(PAYLOAD_BITS))
      cfg_nbits = 4'(PAYLOAD_BITS);
`ifdef UART_TX_PARITY_EN
    par_bit_new = (cfg_parity == 2'b10);
    for (int unsigned i = 0; i < PAYLOAD_BITS; i++) begin
      if (i < 32'(cfg_nbits)) par_bit_new = par_bit_new ^ head[i];
    end
    par_en_new = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
`else
    par_bit_new = 1'b0;
    par_en_new  = 1'b0;
`endif
  end

`ifndef UART_TX_PARITY_EN
  logic unused_cfg_parity;
  assign unused_cfg_parity = ^cfg_parity;
`endif

  // FIFO pointers, occupancy and storage writes
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= tx_wr_data;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Frame FSM with bit timer; txd and done are registered from the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      shift_q   <= '0;
      nbits_q   <= '0;
      bitcnt_q  <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      txd_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_START:  txd_q <= 1'b0;
        S_DATA:   txd_q <= shift_q[0];
        S_PARITY: txd_q <= par_bit_q;
        default:  txd_q <= 1'b1;
      endcase

      if (state_q == S_IDLE) begin
        if (pop) begin
          shift_q   <= head;
          nbits_q   <= cfg_nbits;
          div_q     <= baud_divider;
          stop2_q   <= cfg_stop2;
          par_en_q  <= par_en_new;
          par_bit_q <= par_bit_new;
          bitcnt_q  <= '0;
          cnt_q     <= '0;
          state_q   <= S_START;
        end
      end else if (!next_bit) begin
        cnt_q <= cnt_q + COUNT_REG_LEN'(1);
      end else begin
        cnt_q <= '0;
        case (state_q)
          S_START: state_q <= S_DATA;
          S_DATA: begin
            shift_q <= {1'b0, shift_q[PAYLOAD_BITS-1:1]};
            if (bitcnt_q == nbits_q - 4'd1)
              state_q <= par_en_q ? S_PARITY : S_STOP1;
            else
              bitcnt_q <= bitcnt_q + 4'd1;
          end
          S_PARITY: state_q <= S_STOP1;
          S_STOP1: begin
            if (stop2_q) begin
              state_q <= S_STOP2;
            end else begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tqvp_uart_tx_fifo.sv
// Bench for tqvp_uart_tx_fifo: a FIFO-plus-frame-schedule reference model is
// stepped every clock and compared against all outputs, alongside a short
// vector table and directed frame sequences. Honours UART_TX_PARITY_EN.
module tb_tqvp_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        uart_txd;
  logic        tx_wr_en;
  logic [7:0]  tx_wr_data;
  logic        tx_full, tx_empty;
  logic [2:0]  tx_level;
  logic        uart_tx_busy, tx_done;
  logic [12:0] baud_divider;
  logic [3:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;

  tqvp_uart_tx_fifo #(
    .COUNT_REG_LEN(13),
    .PAYLOAD_BITS (8),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_txd     (uart_txd),
    .tx_wr_en     (tx_wr_en),
    .tx_wr_data   (tx_wr_data),
    .tx_full      (tx_full),
    .tx_empty     (tx_empty),
    .tx_level     (tx_level),
    .uart_tx_busy (uart_tx_busy),
    .tx_done      (tx_done),
    .baud_divider (baud_divider),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Reference model: a queue for the FIFO plus the schedule of the frame in
  // flight (pop edge, bit list, bit width, total length in cycles).
  logic [7:0] mq[$];
  int   e_cnt = 0;
  int   idle_from = 0;
  int   cur_P, cur_L, cur_bw;
  bit   cur_valid = 1'b0;
  bit   cur_bits[16];
  int   ex_txd, ex_busy, ex_done, ex_level;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int lvl, nb, n, rel;
    logic [7:0] d;
    bit par;
    if (reset) begin
      mq.delete();
      cur_valid = 1'b0;
      idle_from = e_cnt + 1;
    end else begin
      lvl = mq.size();
      if (e_cnt >= idle_from && lvl > 0) begin
        d  = mq.pop_front();
        nb = (cfg_data_bits < 5 || cfg_data_bits > 8) ? 8 : int'(cfg_data_bits);
        n  = 0;
        cur_bits[n] = 1'b0; n++;
        par = (cfg_parity == 2'b10);
        for (int i = 0; i < nb; i++) begin
          cur_bits[n] = d[i]; n++;
          par = par ^ d[i];
        end
`ifdef UART_TX_PARITY_EN
        if (cfg_parity == 2'b01 || cfg_parity == 2'b10) begin
          cur_bits[n] = par; n++;
        end
`endif
        cur_bits[n] = 1'b1; n++;
        if (cfg_stop2) begin
          cur_bits[n] = 1'b1; n++;
        end
        cur_bw    = int'(baud_divider) + 1;
        cur_L     = n * cur_bw;
        cur_P     = e_cnt;
        cur_valid = 1'b1;
        idle_from = e_cnt + cur_L + 1;
      end
      if (tx_wr_en && lvl < 4) mq.push_back(tx_wr_data);
    end
    rel      = e_cnt - cur_P;
    ex_txd   = (cur_valid && rel >= 1 && rel <= cur_L) ? int'(cur_bits[(rel - 1) / cur_bw]) : 1;
    ex_busy  = (cur_valid && rel >= 0 && rel < cur_L) ? 1 : 0;
    ex_done  = (cur_valid && rel == cur_L) ? 1 : 0;
    ex_level = mq.size();
    e_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("txd",   int'(uart_txd),     ex_txd);
    chk("busy",  int'(uart_tx_busy), ex_busy);
    chk("done",  int'(tx_done),      ex_done);
    chk("level", int'(tx_level),     ex_level);
    chk("full",  int'(tx_full),      (ex_level == 4) ? 1 : 0);
    chk("empty", int'(tx_empty),     (ex_level == 0) ? 1 : 0);
  endtask

  task automatic push(input logic [7:0] d);
    tx_wr_en   = 1'b1;
    tx_wr_data = d;
    tick();
    tx_wr_en   = 1'b0;
  endtask

  // Counts busy samples until tx_done is seen; bounded by 'bound' cycles.
  task automatic run_until_done(input int bound, output int len, output bit got);
    len = 0;
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      tick();
      if (tx_done) got = 1'b1;
      else if (uart_tx_busy) len++;
    end
  endtask

  // Pushes one byte into an idle, empty transmitter with divider 0 and
  // records one txd sample per bit starting with the start bit.
  task automatic capture(input logic [7:0] d, output logic [11:0] bits, output int busy_n);
    busy_n = 0;
    push(d);
    tick();
    if (uart_tx_busy) busy_n++;
    for (int i = 0; i < 12; i++) begin
      tick();
      bits[i] = uart_txd;
      if (uart_tx_busy) busy_n++;
    end
  endtask

  typedef struct {
    bit         rst;
    bit         wr;
    logic [7:0] d;
    int         lvl;
    bit         full;
    bit         empty;
    bit         busy;
    bit         txd;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int len, busy_n, dcnt;
    bit got;
    logic [11:0] bits;

    tbl[0] = '{1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 8'hA5, 1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 8'h3C, 1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 8'hFF, 2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 3, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 8'h11, 4, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 8'h22, 4, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 4, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1};

    reset = 1'b1; tx_wr_en = 1'b0; tx_wr_data = '0;
    baud_divider = 13'd100; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;

    // Vector table: FIFO fill, drop when full, reset clearing everything
    for (int i = 0; i < 10; i++) begin
      reset      = tbl[i].rst;
      tx_wr_en   = tbl[i].wr;
      tx_wr_data = tbl[i].d;
      tick();
      reset    = 1'b0;
      tx_wr_en = 1'b0;
      chk($sformatf("tbl%0d_level", i), int'(tx_level),     tbl[i].lvl);
      chk($sformatf("tbl%0d_full", i),  int'(tx_full),      int'(tbl[i].full));
      chk($sformatf("tbl%0d_empty", i), int'(tx_empty),     int'(tbl[i].empty));
      chk($sformatf("tbl%0d_busy", i),  int'(uart_tx_busy), int'(tbl[i].busy));
      chk($sformatf("tbl%0d_txd", i),   int'(uart_txd),     int'(tbl[i].txd));
    end

    // 0x55, divider 3, 8N1: latency, busy length, single done
    baud_divider = 13'd3;
    push(8'h55);
    tick();
    chk("lat_e1_txd",  int'(uart_txd), 1);
    chk("lat_e1_busy", int'(uart_tx_busy), 1);
    tick();
    chk("lat_e2_txd",  int'(uart_txd), 0);
    run_until_done(100, len, got);
    chk("f55_done_seen", int'(got), 1);
    chk("f55_busy_len", len + 2, 40);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_done) dcnt++;
    end
    chk("f55_done_once", dcnt, 0);

    // Filler frame in flight, then four queued bytes fill the FIFO, fifth dropped
    baud_divider = 13'd2;
    push(8'h11);
    tick();
    push(8'hA5); push(8'h3C); push(8'hFF); push(8'h00);
    chk("full_after_4", int'(tx_full), 1);
    push(8'h77);
    chk("level_after_drop", int'(tx_level), 4);
    for (int k = 0; k < 5; k++) begin
      run_until_done(200, len, got);
      chk($sformatf("b2b%0d_done", k), int'(got), 1);
      if (k == 1) chk("b2b1_len", len, 28);
      if (k >= 2) chk($sformatf("b2b%0d_len", k), len, 30);
      if (k == 0) begin
        tick();
        chk("gap_high", int'(uart_txd), 1);
        tick();
        chk("gap_start", int'(uart_txd), 0);
      end
    end
    tick();
    chk("b2b_empty_end", int'(tx_empty), 1);

    // 7 data bits, even parity, two stop bits, 0x83, divider 0
    baud_divider = 13'd0; cfg_data_bits = 4'd7; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
    capture(8'h83, bits, busy_n);
`ifdef UART_TX_PARITY_EN
    chk("f83_bits", int'(bits), 12'hE06);
    chk("f83_len", busy_n, 11);
`else
    chk("f83_bits", int'(bits), 12'hF06);
    chk("f83_len", busy_n, 10);
`endif
    for (int i = 0; i < 4; i++) tick();

    // Odd parity, 0x00, 8 bits, one stop bit
    cfg_data_bits = 4'd8; cfg_parity = 2'b10; cfg_stop2 = 1'b0;
    capture(8'h00, bits, busy_n);
    chk("f00_bits", int'(bits), 12'hE00);
`ifdef UART_TX_PARITY_EN
    chk("f00_len", busy_n, 11);
`else
    chk("f00_len", busy_n, 10);
`endif
    for (int i = 0; i < 4; i++) tick();

    // Settings change during frame 1 affect only frame 2
    cfg_parity = 2'b00; baud_divider = 13'd1; cfg_stop2 = 1'b0;
    push(8'h5A);
    push(8'hC3);
    for (int i = 0; i < 3; i++) tick();
    cfg_stop2 = 1'b1; baud_divider = 13'd3;
    run_until_done(200, len, got);
    chk("cfg_f1_done", int'(got), 1);
    chk("cfg_f1_len", len, 16);
    run_until_done(200, len, got);
    chk("cfg_f2_done", int'(got), 1);
    chk("cfg_f2_len", len, 44);
    cfg_stop2 = 1'b0;

    // Reset during DATA of the second queued frame
    push(8'h0F); push(8'hF0); push(8'h3C);
    run_until_done(200, len, got);
    chk("rst_f1_done", int'(got), 1);
    for (int i = 0; i < 8; i++) tick();
    chk("pre_rst_busy",  int'(uart_tx_busy), 1);
    chk("pre_rst_level", int'(tx_level), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_txd",   int'(uart_txd), 1);
    chk("rst_level", int'(tx_level), 0);
    chk("rst_busy",  int'(uart_tx_busy), 0);
    chk("rst_done",  int'(tx_done), 0);
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx_done) dcnt++;
    end
    chk("no_done_after_reset", dcnt, 0);

    // Randomized traffic and settings against the model
    for (int i = 0; i < 3000; i++) begin
      tx_wr_en   = ($urandom_range(0, 2) == 0);
      tx_wr_data = 8'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        baud_divider  = 13'($urandom_range(0, 3));
        cfg_data_bits = 4'($urandom_range(0, 15));
        cfg_parity    = 2'($urandom_range(0, 3));
        cfg_stop2     = 1'($urandom_range(0, 1));
      end
      reset = ($urandom_range(0, 400) == 0);
      tick();
    end
    reset = 1'b0;
    tx_wr_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
